seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 8; number of multiplexed digits, legal range 1..16.
REQ-002 Parameter SCAN_DIV, default 100000; clock cycles per digit slot, legal range at least 2.
REQ-003 Parameter LZB, default 0; 1 enables leading-zero blanking.
REQ-004 Parameter SEG_ACT_HIGH, default 1; 1 drives seg/dp active-high (common-cathode), 0 inverts them.
REQ-005 Parameter AN_ACT_HIGH, default 0; 1 drives an active-high, 0 drives it active-low.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 data  in  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost.
REQ-009 dp_in  in  N_DIGITS  decimal-point request per digit.
REQ-010 dig_en  in  N_DIGITS  per-digit enable; 0 blanks that digit.
REQ-011 load  in  1  single-cycle strobe; captures data/dp_in/dig_en into the shadow registers.
REQ-012 seg  out  7  segments; bit 6 = A through bit 0 = G.
REQ-013 dp  out  1  decimal-point segment.
REQ-014 an  out  N_DIGITS  digit select, one-hot when a digit is lit.

Function
REQ-015 Prescaler counts 0..SCAN_DIV-1; tick asserts in the cycle the count equals SCAN_DIV-1, and the count then returns to 0.
REQ-016 On tick, digit index idx advances by 1; from N_DIGITS-1 it wraps to 0; with N_DIGITS=1, idx stays at 0.
REQ-017 When load=1 at a clock edge, shadow <= {data, dp_in, dig_en}; otherwise shadow holds; load is independent of tick.
REQ-018 seg, dp and an are registered from the current idx and shadow with 1-cycle latency; no combinational path from any input to any output.
REQ-019 Decode, A..G, logical on: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 c=0001101 d=0111101 E=1001111 F=1000111.
REQ-020 Digit idx is blank when dig_en[idx]=0, or when LZB=1, idx>0, and every enabled nibble at index ≥ idx is 0; digit 0 is never zero-blanked.
REQ-021 A blank digit drives an, seg and dp all inactive for its slot.
REQ-022 A lit digit drives an[idx] active and every other an bit inactive; seg shows the decode of nibble idx and dp shows dp_in[idx].
REQ-023 Polarity inversion by SEG_ACT_HIGH/AN_ACT_HIGH applies at the output register only.
REQ-024 Load and tick in the same cycle: the new shadow is used from the next output update onward, and the scan sequence is not disturbed.
REQ-025 Out-of-range idx is unreachable; if it is reached, idx returns to 0 on the next tick.

Reset
REQ-026 While rst_n=0: prescaler=0, idx=0, shadow data=0, shadow dp=0, shadow dig_en=0, and all outputs inactive per their polarity parameters.
REQ-027 Reset asserted mid-scan or mid-load SHALL take effect immediately, independent of clk.
REQ-028 After deassertion, operation resumes from the reset state, and the first tick follows after SCAN_DIV cycles.

Structure
REQ-029 Package seg7_pkg holds the 16-entry segment pattern constant table, the segment bit-index constants (A=6..G=0), and the SEG_OFF constant.
REQ-030 One sub-module, seg7_decode: combinational, 4-bit nibble in, 7-bit active-high pattern out, from the seg7_pkg table.
REQ-031 seg7_scan_driver holds the prescaler, idx, shadow, blanking logic and output registers.

Verification (N_DIGITS=4, SCAN_DIV=4, defaults otherwise unless stated)
REQ-032 Reset release, then load with data=16'h12AF, dig_en=4'hF -> an cycles 1110,1101,1011,0111 and repeats every 16 cycles; seg per slot = 1000111, 1110111, 1101101, 0110000.
REQ-033 Decode sweep: each nibble 0..F in turn on digit 0 with N_DIGITS=1 -> seg matches the REQ-019 table.
REQ-034 LZB=1, data=16'h0030 -> digit 3 blank (an inactive, seg 0000000); digit 2 blank; digit 1 shows 1111001; digit 0 shows 1111110; data=16'h0000 -> only digit 0 lit.
REQ-035 dig_en=4'b0101, dp_in=4'b0001 -> an never selects digits 1 or 3; dp=1 only during the digit-0 slot.
REQ-036 load asserted on the tick cycle with a new value -> scan order is unbroken, and the new value appears at the first output update after that edge.
REQ-037 rst_n pulled low mid-slot without a clock edge -> outputs go inactive immediately; after release the first tick follows after 4 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   SEG_A..SEG_G : bit positions of each segment inside a 7-bit pattern (A = MSB).
//   SEG_OFF      : all-segments-off pattern (logical, before polarity).
//   SEG_TABLE    : hex nibble -> active-high A..G pattern.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b111_1110,  // 0
        7'b011_0000,  // 1
        7'b110_1101,  // 2
        7'b111_1001,  // 3
        7'b011_0011,  // 4
        7'b101_1011,  // 5
        7'b101_1111,  // 6
        7'b111_0000,  // 7
        7'b111_1111,  // 8
        7'b111_1011,  // 9
        7'b111_0111,  // A
        7'b001_1111,  // b
        7'b000_1101,  // c
        7'b011_1101,  // d
        7'b100_1111,  // E
        7'b100_0111   // F
    };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex-nibble to 7-segment decoder.
//   nibble  : 4-bit hex value
//   pattern : active-high segment pattern, bit 6 = A .. bit 0 = G
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Pure table lookup; every nibble value has an entry.
    always_comb begin
        pattern = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for N_DIGITS 7-segment digits.
//   clk, rst_n : system clock, asynchronous active-low reset
//   data       : 4 bits per digit, digit 0 in the low nibble (rightmost)
//   dp_in      : decimal-point request per digit
//   dig_en     : per-digit enable, 0 blanks the digit
//   load       : one-cycle strobe capturing data/dp_in/dig_en into the shadow
//   seg, dp    : segment and decimal-point drive (polarity via SEG_ACT_HIGH)
//   an         : digit select, one-hot while a digit is lit (polarity via AN_ACT_HIGH)
// Outputs are registered from the current digit index and shadow, so the
// visible slot lags the index by one clock.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int LZB          = 0,
    parameter int SEG_ACT_HIGH = 1,
    parameter int AN_ACT_HIGH  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   dig_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};

    // XOR masks turning logical-on patterns into pin levels.
    localparam logic [6:0]          SEG_XOR = (SEG_ACT_HIGH != 0) ? 7'h00 : 7'h7F;
    localparam logic                DP_XOR  = (SEG_ACT_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic [N_DIGITS-1:0] AN_XOR  = (AN_ACT_HIGH != 0) ? {N_DIGITS{1'b0}}
                                                                 : {N_DIGITS{1'b1}};

    logic [PW-1:0]         presc_r;
    logic [IW-1:0]         idx_r;
    logic [4*N_DIGITS-1:0] data_sh_r;
    logic [N_DIGITS-1:0]   dp_sh_r;
    logic [N_DIGITS-1:0]   en_sh_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [N_DIGITS-1:0]   an_r;

    logic                  tick_s;
    logic [N_DIGITS-1:0]   onehot_s;
    logic [3:0]            nib_s;
    logic                  dp_sel_s;
    logic                  en_sel_s;
    logic                  in_range_s;
    logic                  upper_zero_s;
    logic                  blank_s;
    logic [6:0]            pat_s;
    logic [6:0]            seg_nxt_s;
    logic                  dp_nxt_s;
    logic [N_DIGITS-1:0]   an_nxt_s;

    assign tick_s = (presc_r == PRESC_MAX);

    // Slot prescaler: counts 0..SCAN_DIV-1 and wraps on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Digit index: advances on tick; last digit or any stray value wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= IDX_ZERO;
        end else if (tick_s) begin
            if (!in_range_s || (idx_r == IDX_MAX)) begin
                idx_r <= IDX_ZERO;
            end else begin
                idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Shadow registers: captured on load, independent of the scan timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sh_r <= {(4*N_DIGITS){1'b0}};
            dp_sh_r   <= {N_DIGITS{1'b0}};
            en_sh_r   <= {N_DIGITS{1'b0}};
        end else if (load) begin
            data_sh_r <= data;
            dp_sh_r   <= dp_in;
            en_sh_r   <= dig_en;
        end else begin
            data_sh_r <= data_sh_r;
            dp_sh_r   <= dp_sh_r;
            en_sh_r   <= en_sh_r;
        end
    end

    // Select the current digit and evaluate leading-zero blanking. The
    // one-hot select doubles as the range check, so a stray idx blanks.
    always_comb begin
        onehot_s     = {N_DIGITS{1'b0}};
        nib_s        = 4'h0;
        dp_sel_s     = 1'b0;
        en_sel_s     = 1'b0;
        upper_zero_s = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            onehot_s[i]  = (idx_r == IW'(i));
            nib_s        = nib_s | (data_sh_r[4*i +: 4] & {4{onehot_s[i]}});
            dp_sel_s     = dp_sel_s | (dp_sh_r[i] & onehot_s[i]);
            en_sel_s     = en_sel_s | (en_sh_r[i] & onehot_s[i]);
            // Disabled digits never hold the current digit lit.
            upper_zero_s = upper_zero_s & ~((i >= int'(idx_r)) && en_sh_r[i]
                                            && (data_sh_r[4*i +: 4] != 4'h0));
        end
        in_range_s = |onehot_s;
        blank_s    = !in_range_s || !en_sel_s
                     || ((LZB != 0) && (idx_r != IDX_ZERO) && upper_zero_s);
    end

    seg7_decode u_decode (
        .nibble  (nib_s),
        .pattern (pat_s)
    );

    // Logical (active-high) next output values for the current slot.
    always_comb begin
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b0;
        an_nxt_s  = {N_DIGITS{1'b0}};
        if (blank_s) begin
            seg_nxt_s = SEG_OFF;
            dp_nxt_s  = 1'b0;
            an_nxt_s  = {N_DIGITS{1'b0}};
        end else begin
            seg_nxt_s = pat_s;
            dp_nxt_s  = dp_sel_s;
            an_nxt_s  = onehot_s;
        end
    end

    // Output registers; polarity is applied only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_OFF ^ SEG_XOR;
            dp_r  <= DP_XOR;
            an_r  <= AN_XOR;
        end else begin
            seg_r <= seg_nxt_s ^ SEG_XOR;
            dp_r  <= dp_nxt_s ^ DP_XOR;
            an_r  <= an_nxt_s ^ AN_XOR;
        end
    end

    assign seg = seg_r;
    assign dp  = dp_r;
    assign an  = an_r;

endmodule
